// File: rtl/usb_fifo_pkg.sv
// Shared constants for the USB RX FIFO slice: byte width, count output width
// and the default FIFO depth.
package usb_fifo_pkg;

  localparam int BYTE_W             = 8;
  localparam int COUNT_W            = 16;
  localparam int DEFAULT_FIFO_DEPTH = 64;

endpackage : usb_fifo_pkg

// File: rtl/usb_fifo_dpram.sv
// FIFO storage: synchronous write port, asynchronous read port.
// Kept separate so a vendor RAM with the same port behaviour can drop in.
module usb_fifo_dpram
  import usb_fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  busClk,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [BYTE_W-1:0]     wrData,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [BYTE_W-1:0]     rdData
);

  logic [BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge busClk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Read is combinational so the head byte falls through without latency.
  assign rdData = mem[rdAddr];

endmodule : usb_fifo_dpram

// File: rtl/usb_rx_fifo_sync.sv
// Single-clock first-word-fall-through RX byte FIFO between the USB receive path
// and the bus interface. Define USB_RX_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module usb_rx_fifo_sync
  import usb_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = 6
) (
  input  logic               busClk,
  input  logic               rstn,
  input  logic               fifoWEn,
  input  logic [BYTE_W-1:0]  fifoDataIn,
  input  logic               fifoREn,
  output logic [BYTE_W-1:0]  fifoDataOut,
  input  logic               forceEmpty,
  output logic [COUNT_W-1:0] numElementsInFifo,
  output logic               fifoFull,
  output logic               fifoEmpty
`ifdef USB_RX_FIFO_ERR_FLAGS_EN
  ,
  output logic               overflowErr,
  output logic               underflowErr
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wrAccept;
  logic                  rdAccept;
  logic                  memWe;

  // Strobe semantics: fifoWEn/fifoREn act as valid; the implicit ready is
  // "not full" for writes (or a same-cycle accepted read) and "not empty" for
  // reads. A strobe without ready is dropped, never held or retried.
  assign rdAccept = fifoREn && !fifoEmpty;
  assign wrAccept = fifoWEn && (!fifoFull || rdAccept);
  assign memWe    = wrAccept && !forceEmpty && rstn;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == FULL_COUNT);

  always_comb begin
    numElementsInFifo               = '0;
    numElementsInFifo[ADDR_WIDTH:0] = count;
  end

  always_ff @(posedge busClk or negedge rstn) begin
    if (!rstn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (forceEmpty) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrAccept) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (rdAccept) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (wrAccept && !rdAccept) begin
        count <= count + 1'b1;
      end else if (rdAccept && !wrAccept) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef USB_RX_FIFO_ERR_FLAGS_EN
  always_ff @(posedge busClk or negedge rstn) begin
    if (!rstn) begin
      overflowErr  <= 1'b0;
      underflowErr <= 1'b0;
    end else if (forceEmpty) begin
      overflowErr  <= 1'b0;
      underflowErr <= 1'b0;
    end else begin
      if (fifoWEn && !wrAccept) begin
        overflowErr <= 1'b1;
      end
      if (fifoREn && fifoEmpty) begin
        underflowErr <= 1'b1;
      end
    end
  end
`endif

  usb_fifo_dpram #(
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dpram (
    .busClk (busClk),
    .wrEn   (memWe),
    .wrAddr (wrPtr),
    .wrData (fifoDataIn),
    .rdAddr (rdPtr),
    .rdData (fifoDataOut)
  );

endmodule : usb_rx_fifo_sync

// File: doc/usb_rx_fifo_sync.md
Name: usb_rx_fifo_sync

Overview:
- Single-clock RX data FIFO sitting directly upstream of the RX FIFO bus interface.
- The USB slave receive path pushes received bytes in on the write side.
- The bus interface pops bytes, reads the element count, and issues force-empty.
- First-word-fall-through: the head byte is always visible on fifoDataOut without a read-latency cycle.

Parameters:
- FIFO_DEPTH, 64, number of byte entries; must be a power of 2, from 4 to 32768.
- ADDR_WIDTH, 6, log2(FIFO_DEPTH); pointer width.

Ports:
- busClk  in  1  single clock for both FIFO sides.
- rstn  in  1  asynchronous, active-low reset.
- fifoWEn  in  1  write strobe from the USB RX path; one byte per cycle.
- fifoDataIn  in  8  write data.
- fifoREn  in  1  read strobe from the bus interface; pops the head byte.
- fifoDataOut  out  8  head byte (mem[rdPtr]), combinational from storage.
- forceEmpty  in  1  one-cycle pulse; discards all contents.
- numElementsInFifo  out  16  current occupancy, zero-extended.
- fifoFull  out  1  occupancy == FIFO_DEPTH.
- fifoEmpty  out  1  occupancy == 0.

Behaviour:
- Reset (rstn low, asynchronous):
  - wrPtr = rdPtr = 0, count = 0.
  - fifoEmpty = 1, fifoFull = 0, numElementsInFifo = 16'h0000.
  - Storage contents undefined; fifoDataOut is don't-care while empty.
- Pointers and count:
  - wrPtr and rdPtr are ADDR_WIDTH bits and wrap naturally modulo FIFO_DEPTH.
  - count is ADDR_WIDTH+1 bits, zero-extended to 16 bits on numElementsInFifo.
- Write accepted when fifoWEn=1 and (not full, or fifoREn=1 the same cycle and not empty):
  - mem[wrPtr] <= fifoDataIn; wrPtr increments.
- Read accepted when fifoREn=1 and not empty:
  - rdPtr increments; fifoDataOut shows the next byte in the following cycle.
- Count update:
  - +1 on write only, -1 on read only, unchanged on both.
- Latency:
  - A byte written at edge N is visible on fifoDataOut and counted from edge N.
  - On empty→non-empty, fifoEmpty deasserts after edge N.
- Boundary rules:
  - Write while full without a read: byte dropped; state unchanged.
  - Write while full with a read: both accepted; stays full.
  - Read while empty: ignored, even if fifoWEn=1 that cycle; the write is still accepted.
  - Flags are registered-equivalent, derived from count only; never combinational from strobes.
- forceEmpty:
  - Highest priority. At the next edge, wrPtr = rdPtr = 0 and count = 0.
  - A write or read in the same cycle is discarded.
  - forceEmpty held for several cycles keeps the FIFO empty.
- Asynchronous reset mid-transfer aborts immediately to the reset state; no partial write completes.

Optional Feature:
- Macro: USB_RX_FIFO_ERR_FLAGS_EN.
- When defined:
  - Adds outputs overflowErr (1) and underflowErr (1), both sticky, reset 0.
  - overflowErr sets on a dropped write.
  - underflowErr sets on an ignored read.
  - Both clear on forceEmpty; forceEmpty wins over a same-cycle set.
- When undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package usb_fifo_pkg holds:
  - byte width constant (8).
  - count output width constant (16).
  - default FIFO_DEPTH.
- Sub-module usb_fifo_dpram:
  - FIFO_DEPTH x 8 array with a synchronous write port and an asynchronous read port.
  - Isolated so a vendor RAM can be substituted.
- Pointer, count and flag logic stay in the top.

Test Plan:
- Reset, then write 0xA5 → next cycle fifoDataOut=0xA5, numElementsInFifo=1, fifoEmpty=0. Read → count=0, fifoEmpty=1.
- Write 64 bytes 0x00..0x3F → fifoFull=1, count=64. 65th write (0xFF) dropped. Read all 64 → sequence 0x00..0x3F in order, then fifoEmpty=1.
- Fill to full, then simultaneous write 0x77 and read → output 0x00 popped, count stays 64. Last byte read out is 0x77.
- Empty FIFO, simultaneous write 0x11 and read → read ignored, count=1, fifoDataOut=0x11. With the macro, underflowErr=1.
- Write 10 bytes, then forceEmpty coincident with write 0x99 → count=0, fifoEmpty=1. Subsequent write 0x22 reads back 0x22 (0x99 not present).
- Write 5 bytes, assert rstn=0 between edges → outputs go to the reset values immediately. After release, count=0 and wrap across the pointer boundary (70 writes/reads interleaved) preserves order.
